phys_regfile_rdy: RTL and testbench
===================================

// Module: phys_regfile_rdy
// PURPOSE
//  Multi-ported physical register file with per-register ready (scoreboard) bits.
//  Sits between rename and issue: rename allocates destination tags (ready cleared) and issue reads operands + readiness.
//  Writeback writes data and sets ready; flush marks all registers ready for mispredict recovery.
// PARAMETERS
//  PHYS_SZ   64  number of physical registers; tag width TAG_W = $clog2(PHYS_SZ)
//  DATA_W    32  register width in bits
//  NUM_RD    4   read ports (two per issue slot at SUPER=2)
//  NUM_WR    2   writeback ports
//  NUM_ALLOC 2   allocate (rename) ports
// PORTS
//  clk         in   1               clock, all state updates on posedge
//  rst         in   1               synchronous, active-low reset
//  rd_tag      in   NUM_RD*TAG_W    read tags
//  rd_data     out  NUM_RD*DATA_W   read data
//  rd_rdy      out  NUM_RD          ready bit of rd_tag
//  wr_en       in   NUM_WR          writeback valid
//  wr_tag      in   NUM_WR*TAG_W    writeback destination
//  wr_data     in   NUM_WR*DATA_W   writeback value
//  alloc_en    in   NUM_ALLOC       allocate valid
//  alloc_tag   in   NUM_ALLOC*TAG_W tag newly assigned as destination
//  flush       in   1               recovery: all ready bits set next cycle
//  rdy_vec     out  PHYS_SZ         registered ready bits, for wakeup logic
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all registers 0, all ready bits 1; rd_rdy=1, rdy_vec all-ones, rd_data=0 one cycle later.
//  - Reads combinational off stored state: rd_data[i]=reg[rd_tag[i]], rd_rdy[i]=rdy[rd_tag[i]].
//  - Write: wr_en[j] -> reg[wr_tag[j]] <= wr_data[j], rdy[wr_tag[j]] <= 1 at next posedge.
//  - Same-tag writes in one cycle: highest port index wins (data); ready set either way.
//  - Allocate: alloc_en[k] -> rdy[alloc_tag[k]] <= 0; data untouched.
//  - Alloc and write to same tag same cycle: alloc wins (rdy=0, data still written).
//  - flush: every rdy <= 1; overrides alloc and write ready effects; data writes in the flush cycle still commit.
//  - Tag 0 is ordinary (no hardwired zero); out-of-range tags impossible (PHYS_SZ power of two).
//  - Reset has priority over flush, alloc, write; reset mid-stream drops all in-flight updates.
//  - Reads during reset cycle reflect pre-reset stored state.
// CONFIGURATION
//  PRF_BYPASS_EN defined: same-cycle forwarding; rd_data/rd_rdy see that cycle's writes
//   (highest wr port whose wr_tag matches), so a dependent issues the same cycle its producer writes back.
//   Alloc/flush are NOT forwarded (take effect next cycle).
//  PRF_BYPASS_EN undefined: reads see stored state only; result visible one cycle after write.
// STRUCTURE
//  - Package prf_pkg: typedef word (DATA_W logic), typedef ptag_t (TAG_W logic), PHYS_SZ/NUM_* constants.
//  - Sub-module phys_ready_table: owns rdy[PHYS_SZ] + alloc/write/flush priority, drives rdy_vec and rd_rdy.
//  - Top: data array, write-merge loop, read mux, optional bypass mux.
// TESTING
//  - Reset: hold rst=0 2 cycles -> rdy_vec=all 1s, rd_data=0 on every port for any tag.
//  - Alloc tag 5 -> next cycle rd_rdy=0 for tag 5; write tag5=0xDEADBEEF -> next cycle rd_rdy=1, rd_data=0xDEADBEEF.
//  - wr port0 and port1 both tag 9 (0x11, 0x22) -> reg9=0x22, rdy9=1.
//  - Same cycle alloc tag 7 + write tag 7=0xAA -> rdy7=0, reg7=0xAA.
//  - Alloc tags 3,4; flush next cycle with alloc tag 6 -> after flush rdy_vec all 1s.
//  - PRF_BYPASS_EN: write tag 12=0x55 while reading 12 -> same-cycle rd_data=0x55, rd_rdy=1; undefined -> old value, then 0x55.

Source files
------------

// File: rtl/prf_pkg.sv
// Shared sizing constants and types for the physical register file.
// Ports: none (package only).
package prf_pkg;
  localparam int PHYS_SZ   = 64;
  localparam int TAG_W     = $clog2(PHYS_SZ);
  localparam int DATA_W    = 32;
  localparam int NUM_RD    = 4;
  localparam int NUM_WR    = 2;
  localparam int NUM_ALLOC = 2;

  typedef logic [DATA_W-1:0] word;
  typedef logic [TAG_W-1:0]  ptag_t;
endpackage

// File: rtl/phys_regfile_rdy_ready.sv
// Per-register ready (scoreboard) bits with write/alloc/flush priority.
// Ports: clk, rst (sync active-low), wr_*/alloc_*/flush in, rd_tag in,
//        rdy_vec out (registered bits), rd_rdy out (stored-state lookup).
module phys_ready_table
  import prf_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*TAG_W-1:0]    wr_tag,
  input  logic [NUM_ALLOC-1:0]       alloc_en,
  input  logic [NUM_ALLOC*TAG_W-1:0] alloc_tag,
  input  logic                       flush,
  input  logic [NUM_RD*TAG_W-1:0]    rd_tag,
  output logic [NUM_RD-1:0]          rd_rdy,
  output logic [PHYS_SZ-1:0]         rdy_vec
);
  logic [PHYS_SZ-1:0] rdy_q;
  logic [PHYS_SZ-1:0] rdy_d;

  // Later assignments take priority: write < alloc < flush.
  always_comb begin
    rdy_d = rdy_q;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j]) rdy_d[wr_tag[j*TAG_W +: TAG_W]] = 1'b1;
    for (int k = 0; k < NUM_ALLOC; k++)
      if (alloc_en[k]) rdy_d[alloc_tag[k*TAG_W +: TAG_W]] = 1'b0;
    if (flush) rdy_d = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst) rdy_q <= '1;
    else      rdy_q <= rdy_d;
  end

  always_comb begin
    rd_rdy = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_rdy[i] = rdy_q[rd_tag[i*TAG_W +: TAG_W]];
  end

  assign rdy_vec = rdy_q;
endmodule

// File: rtl/phys_regfile_rdy.sv
// Multi-ported physical register file with per-register ready bits.
// Ports: clk, rst (sync active-low), rd_tag/rd_data/rd_rdy read ports,
//        wr_en/wr_tag/wr_data writeback, alloc_en/alloc_tag rename,
//        flush recovery, rdy_vec registered ready bits.
// Macro PRF_BYPASS_EN: forward same-cycle writebacks onto read ports.
module phys_regfile_rdy
  import prf_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*TAG_W-1:0]    rd_tag,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_rdy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*TAG_W-1:0]    wr_tag,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_ALLOC-1:0]       alloc_en,
  input  logic [NUM_ALLOC*TAG_W-1:0] alloc_tag,
  input  logic                       flush,
  output logic [PHYS_SZ-1:0]         rdy_vec
);
  word regs_q [PHYS_SZ];
  word regs_d [PHYS_SZ];
  logic [NUM_RD-1:0] rdy_st;

  phys_ready_table u_rdy (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_tag    (wr_tag),
    .alloc_en  (alloc_en),
    .alloc_tag (alloc_tag),
    .flush     (flush),
    .rd_tag    (rd_tag),
    .rd_rdy    (rdy_st),
    .rdy_vec   (rdy_vec)
  );

  // Higher write port overwrites lower on a tag collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j])
        regs_d[wr_tag[j*TAG_W +: TAG_W]] =
          wr_data[j*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < PHYS_SZ; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_rdy  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs_q[rd_tag[i*TAG_W +: TAG_W]];
      rd_rdy[i] = rdy_st[i];
`ifdef PRF_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] &&
            wr_tag[j*TAG_W +: TAG_W] == rd_tag[i*TAG_W +: TAG_W]) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
          rd_rdy[i] = 1'b1;
        end
`endif
    end
  end
endmodule

// File: tb/tb_phys_regfile_rdy.sv
// Directed self-checking bench for phys_regfile_rdy.
// Exercises reset, alloc/write/flush priority and optional bypass.
module tb_phys_regfile_rdy;
  import prf_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_RD*TAG_W-1:0]    rd_tag;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_rdy;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*TAG_W-1:0]    wr_tag;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic [NUM_ALLOC-1:0]       alloc_en;
  logic [NUM_ALLOC*TAG_W-1:0] alloc_tag;
  logic                       flush;
  logic [PHYS_SZ-1:0]         rdy_vec;

  int errors = 0;
  int checks = 0;

  phys_regfile_rdy dut (
    .clk       (clk),
    .rst       (rst),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .rd_rdy    (rd_rdy),
    .wr_en     (wr_en),
    .wr_tag    (wr_tag),
    .wr_data   (wr_data),
    .alloc_en  (alloc_en),
    .alloc_tag (alloc_tag),
    .flush     (flush),
    .rdy_vec   (rdy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_tag = '0; wr_data = '0;
    alloc_en = '0; alloc_tag = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic set_rd(input int p, input int t);
    rd_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  task automatic wr(input int p, input int t, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
    wr_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic al(input int p, input int t);
    alloc_en[p] = 1'b1;
    alloc_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  function automatic logic [31:0] rdp(input int p);
    return rd_data[p*DATA_W +: DATA_W];
  endfunction

  initial begin
    rst = 1'b0;
    rd_tag = '0;
    idle();
    tick();
    tick();
    set_rd(0, 0); set_rd(1, 5); set_rd(2, 63); set_rd(3, 12);
    #1;
    check("reset_rdy_vec", 64'(rdy_vec), {64{1'b1}});
    check("reset_data0", 64'(rdp(0)), 64'h0);
    check("reset_data63", 64'(rdp(2)), 64'h0);
    check("reset_rd_rdy", 64'(rd_rdy), 64'hF);
    rst = 1'b1;

    al(0, 5);
    tick();
    check("alloc5_rd_rdy", 64'(rd_rdy[1]), 64'h0);
    check("alloc5_vec", 64'(rdy_vec[5:4]), 64'h1);

    wr(0, 5, 32'hDEADBEEF);
    #1;
`ifdef PRF_BYPASS_EN
    check("byp5_data", 64'(rdp(1)), 64'hDEADBEEF);
    check("byp5_rdy", 64'(rd_rdy[1]), 64'h1);
`else
    check("nobyp5_data", 64'(rdp(1)), 64'h0);
    check("nobyp5_rdy", 64'(rd_rdy[1]), 64'h0);
`endif
    tick();
    check("wr5_data", 64'(rdp(1)), 64'hDEADBEEF);
    check("wr5_rdy", 64'(rd_rdy[1]), 64'h1);

    set_rd(1, 9);
    al(1, 9);
    tick();
    check("alloc9_rdy", 64'(rd_rdy[1]), 64'h0);
    wr(0, 9, 32'h11); wr(1, 9, 32'h22);
    #1;
`ifdef PRF_BYPASS_EN
    check("byp9_prio", 64'(rdp(1)), 64'h22);
`endif
    tick();
    check("wr9_prio_data", 64'(rdp(1)), 64'h22);
    check("wr9_rdy", 64'(rd_rdy[1]), 64'h1);

    set_rd(2, 7);
    al(0, 7); wr(1, 7, 32'hAA);
    tick();
    check("aw7_rdy", 64'(rd_rdy[2]), 64'h0);
    check("aw7_data", 64'(rdp(2)), 64'hAA);

    al(0, 3); al(1, 4);
    tick();
    check("alloc34_vec", 64'(rdy_vec[4:3]), 64'h0);
    flush = 1'b1; al(0, 6); wr(0, 20, 32'h77);
    set_rd(2, 20);
    tick();
    check("flush_vec", 64'(rdy_vec), {64{1'b1}});
    check("flush_wr20", 64'(rdp(2)), 64'h77);

    wr(0, 0, 32'h123); wr(1, 63, 32'hCAFE);
    set_rd(0, 0); set_rd(2, 63);
    tick();
    check("tag0_data", 64'(rdp(0)), 64'h123);
    check("tag63_data", 64'(rdp(2)), 64'hCAFE);

    al(0, 12);
    tick();
    check("alloc12_rdy", 64'(rd_rdy[3]), 64'h0);
    wr(1, 12, 32'h55);
    #1;
`ifdef PRF_BYPASS_EN
    check("byp12_data", 64'(rdp(3)), 64'h55);
    check("byp12_rdy", 64'(rd_rdy[3]), 64'h1);
`else
    check("nobyp12_data", 64'(rdp(3)), 64'h0);
    check("nobyp12_rdy", 64'(rd_rdy[3]), 64'h0);
`endif
    tick();
    check("wr12_data", 64'(rdp(3)), 64'h55);
    check("wr12_rdy", 64'(rd_rdy[3]), 64'h1);

    set_rd(1, 5); set_rd(2, 30); set_rd(3, 31);
    rst = 1'b0;
    wr(0, 30, 32'h99); al(0, 31);
    #1;
    check("prerst_data5", 64'(rdp(1)), 64'hDEADBEEF);
    tick();
    rst = 1'b1;
    #1;
    check("rst_data5", 64'(rdp(1)), 64'h0);
    check("rst_drop_wr30", 64'(rdp(2)), 64'h0);
    check("rst_vec", 64'(rdy_vec), {64{1'b1}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
